// File: rtl/ppu_pkg.sv
// Shared PPU definitions: palette geometry, greyscale mask, arbiter state
// encoding and the palette address mirror.
package ppu_pkg;

  localparam int PAL_ADDR_W = 5;
  localparam int PAL_IDX_W  = 6;
  localparam logic [PAL_IDX_W-1:0] GREY_MASK = 6'h30;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } arb_state_t;

  // $10/$14/$18/$1C are the sprite backdrop aliases of $00/$04/$08/$0C.
  function automatic logic [PAL_ADDR_W-1:0] pal_mirror(input logic [PAL_ADDR_W-1:0] addr);
    return (addr[4] && (addr[1:0] == 2'b00)) ? {1'b0, addr[3:0]} : addr;
  endfunction

endpackage

// File: rtl/palette_ram_arbiter.sv
// 32x6 NES palette RAM shared between the render pipeline and the CPU bus,
// with mirroring, PPUMASK greyscale and a bounded CPU wait while rendering.
module palette_ram_arbiter
  import ppu_pkg::*;
#(
  parameter int CPU_MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pix_valid,
  input  logic [PAL_ADDR_W-1:0] pix_addr,
  input  logic                  greyscale,
  output logic [PAL_IDX_W-1:0]  pal_idx,
  output logic                  pal_valid,
  output logic                  pal_stall,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [PAL_ADDR_W-1:0] cpu_addr,
  input  logic [PAL_IDX_W-1:0]  cpu_wdata,
  output logic                  cpu_ack,
  output logic [PAL_IDX_W-1:0]  cpu_rdata
);

  localparam logic [3:0] MAX_WAIT = 4'(CPU_MAX_WAIT);

  arb_state_t state, state_nxt;
  logic [3:0] wait_cnt, wait_cnt_nxt;
  logic       grant_cpu;

  logic [PAL_ADDR_W-1:0] cpu_phys, pix_phys, ram_addr;
  logic [PAL_IDX_W-1:0]  ram_rd;
  logic [PAL_IDX_W-1:0]  mem [0:31];

  assign cpu_phys = pal_mirror(cpu_addr);
  assign pix_phys = pal_mirror(pix_addr);

  // Single read port: the CPU owns it in its grant cycle, the renderer otherwise.
  assign ram_addr = grant_cpu ? cpu_phys : pix_phys;
  assign ram_rd   = mem[ram_addr];

  // Handshake: cpu_req and its we/addr/wdata stay stable until cpu_ack; the
  // access happens at the grant edge and cpu_ack pulses for exactly the
  // following cycle, during which cpu_req is ignored.
  assign cpu_ack = (state == ST_ACK);

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    grant_cpu    = cpu_req && (state != ST_ACK) &&
                   (!pix_valid || (wait_cnt == MAX_WAIT));
    case (state)
      ST_IDLE: begin
        if (grant_cpu) begin
          state_nxt = ST_ACK;
        end else if (cpu_req) begin
          state_nxt    = ST_WAIT;
          wait_cnt_nxt = 4'd1;
        end
      end
      ST_WAIT: begin
        if (grant_cpu) begin
          state_nxt    = ST_ACK;
          wait_cnt_nxt = 4'd0;
        end else if (!cpu_req) begin
          state_nxt    = ST_IDLE;
          wait_cnt_nxt = 4'd0;
        end else if (wait_cnt != MAX_WAIT) begin
          wait_cnt_nxt = wait_cnt + 4'd1;
        end
      end
      ST_ACK: begin
        state_nxt    = ST_IDLE;
        wait_cnt_nxt = 4'd0;
      end
      default: begin
        state_nxt    = ST_IDLE;
        wait_cnt_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      wait_cnt  <= 4'd0;
      pal_idx   <= '0;
      pal_valid <= 1'b0;
      pal_stall <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      pal_valid <= pix_valid;
      if (pix_valid && !grant_cpu) begin
        pal_idx   <= greyscale ? (ram_rd & GREY_MASK) : ram_rd;
        pal_stall <= 1'b0;
      end else begin
        // A stolen lookup repeats the previous index and flags it.
        pal_stall <= pix_valid;
      end
      if (grant_cpu && !cpu_we) begin
        cpu_rdata <= ram_rd;
      end
    end
  end

  // Contents survive reset; a grant coinciding with rst is dropped.
  always_ff @(posedge clk) begin
    if (!rst && grant_cpu && cpu_we) begin
      mem[cpu_phys] <= cpu_wdata;
    end
  end

endmodule
